// File: rtl/sound_scheduler.sv
// sound_scheduler: edge-triggered, priority-arbitrated square-wave sound generator feeding the codec.
module sound_scheduler #(
  parameter int AMP         = 4000000,
  parameter int CW          = 24,
  parameter int CHOMP_HP    = 113636,
  parameter int CHOMP_DUR   = 12500000,
  parameter int GHOST_HP_A  = 56818,
  parameter int GHOST_HP_B  = 75757,
  parameter int GHOST_ALT   = 2500000,
  parameter int GHOST_DUR   = 25000000,
  parameter int DEATH_HP0   = 28409,
  parameter int DEATH_STEP  = 2000,
  parameter int DEATH_SWEEP = 1250000,
  parameter int DEATH_DUR   = 50000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        chomp,
  input  logic        eatghost,
  input  logic        death,
  input  logic        mute,
  input  logic        write_ready,
  output logic        write,
  output logic [23:0] writedata,
  output logic        busy,
  output logic [1:0]  sound_id
);
  typedef enum logic [1:0] {IDLE = 2'd0, CHOMP = 2'd1, GHOST = 2'd2, DEATH = 2'd3} state_t;
  localparam int DMAX = (DEATH_DUR > GHOST_DUR) ? ((DEATH_DUR > CHOMP_DUR) ? DEATH_DUR : CHOMP_DUR)
                                                : ((GHOST_DUR > CHOMP_DUR) ? GHOST_DUR : CHOMP_DUR);
  // duration counter widened when the longest sound does not fit in CW bits
  localparam int DW = ($clog2(DMAX) > CW) ? $clog2(DMAX) : CW;
  localparam logic [CW-1:0] HMAX = '1;
  localparam logic signed [23:0] POS_V = 24'(AMP);
  localparam logic signed [23:0] NEG_V = -POS_V;
  state_t state, state_n, req_s;
  logic phase, phase_n, toggle, last;
  logic [CW-1:0] tone, tone_n, aux, aux_n, hp, hp_n, hp_init, hp_sat;
  logic [CW:0] hp_sum;
  logic [DW-1:0] dur, dur_n, dur_last;
  logic chomp_q, eatghost_q, death_q;
  assign write = write_ready;
  always_comb begin
    req_s    = (death & ~death_q) ? DEATH : (eatghost & ~eatghost_q) ? GHOST : (chomp & ~chomp_q) ? CHOMP : IDLE;
    hp_init  = (req_s == DEATH) ? CW'(DEATH_HP0) : (req_s == GHOST) ? CW'(GHOST_HP_A) : CW'(CHOMP_HP);
    dur_last = (state == DEATH) ? DW'(DEATH_DUR - 1) : (state == GHOST) ? DW'(GHOST_DUR - 1) : DW'(CHOMP_DUR - 1);
    last     = dur == dur_last;
    hp_sum   = {1'b0, hp} + (CW+1)'(DEATH_STEP);
    hp_sat   = hp_sum[CW] ? HMAX : hp_sum[CW-1:0];
    toggle   = tone >= hp - 1'b1;
    state_n  = state;
    phase_n  = toggle ? ~phase : phase;
    tone_n   = toggle ? '0 : tone + 1'b1;
    aux_n    = aux + 1'b1;
    hp_n     = hp;
    dur_n    = dur + 1'b1;
    if (req_s != IDLE && req_s >= state) begin
      state_n = req_s;
      phase_n = 1'b1;
      tone_n  = '0;
      aux_n   = '0;
      hp_n    = hp_init;
      dur_n   = '0;
    end else if (state == IDLE || last) begin
      state_n = IDLE;
      phase_n = 1'b1;
      tone_n  = '0;
      aux_n   = '0;
      hp_n    = '0;
      dur_n   = '0;
    end else if (state == GHOST && aux == CW'(GHOST_ALT - 1)) begin
      aux_n   = '0;
      hp_n    = (hp == CW'(GHOST_HP_A)) ? CW'(GHOST_HP_B) : CW'(GHOST_HP_A);
      tone_n  = '0;
      phase_n = 1'b1;
    end else if (state == DEATH && aux == CW'(DEATH_SWEEP - 1)) begin
      aux_n = '0;
      hp_n  = hp_sat;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= 1'b1;
      tone       <= '0;
      aux        <= '0;
      hp         <= '0;
      dur        <= '0;
      chomp_q    <= 1'b0;
      eatghost_q <= 1'b0;
      death_q    <= 1'b0;
      writedata  <= '0;
      busy       <= 1'b0;
      sound_id   <= 2'd0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      tone       <= tone_n;
      aux        <= aux_n;
      hp         <= hp_n;
      dur        <= dur_n;
      chomp_q    <= chomp;
      eatghost_q <= eatghost;
      death_q    <= death;
      writedata  <= (state_n != IDLE && !mute) ? (phase_n ? POS_V : NEG_V) : '0;
      busy       <= state_n != IDLE;
      sound_id   <= state_n;
    end
  end
endmodule

// File: tb/tb_sound_scheduler.sv
// tb_sound_scheduler: directed and random stimulus checked against a cycle-time model of each sound.
module tb_sound_scheduler;
  localparam int AMP = 100, CH_HP = 3, CH_DUR = 20, GA = 2, GB = 4, ALT = 8, G_DUR = 30;
  localparam int D_HP0 = 2, D_STEP = 1, SWP = 6, D_DUR = 40;
  logic clk = 0, reset = 1, chomp = 0, eatghost = 0, death = 0, mute = 0, write_ready = 0;
  logic write, busy;
  logic [23:0] writedata;
  logic [1:0] sound_id;
  int vectors = 0, miscompares = 0;
  bit on = 0;
  int cur = 0, t = 0, r;
  bit pc, pg, pd, mq;
  sound_scheduler #(
    .AMP(AMP), .CW(24), .CHOMP_HP(CH_HP), .CHOMP_DUR(CH_DUR), .GHOST_HP_A(GA), .GHOST_HP_B(GB),
    .GHOST_ALT(ALT), .GHOST_DUR(G_DUR), .DEATH_HP0(D_HP0), .DEATH_STEP(D_STEP),
    .DEATH_SWEEP(SWP), .DEATH_DUR(D_DUR)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .chomp(chomp), .eatghost(eatghost), .death(death),
    .mute(mute), .write_ready(write_ready), .write(write), .writedata(writedata),
    .busy(busy), .sound_id(sound_id)
  );
  always #5 clk = ~clk;
  function automatic int dur_of(int s);
    return s == 1 ? CH_DUR : s == 2 ? G_DUR : D_DUR;
  endfunction
  function automatic int dhp(int c);
    int h = D_HP0 + (c / SWP) * D_STEP;
    return h > 16777215 ? 16777215 : h;
  endfunction
  // level at cycle t of a sound: 1 = positive half
  function automatic bit pos_of(int s, int tt);
    int st = 0, c, h;
    bit p = 1;
    if (s == 1) return ((tt / CH_HP) % 2) == 0;
    if (s == 2) begin
      h = ((tt / ALT) % 2) ? GB : GA;
      return (((tt % ALT) / h) % 2) == 0;
    end
    for (int k = 0; k < 1000; k++) begin
      c = st;
      while (c - st < dhp(c) - 1) c++;
      if (tt <= c) return p;
      st = c + 1;
      p = !p;
    end
    return p;
  endfunction
  function automatic int exp_wd();
    return (cur != 0 && !mq) ? (pos_of(cur, t) ? AMP : -AMP) : 0;
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      cur = 0; t = 0; pc = 0; pg = 0; pd = 0; mq = 0;
    end else begin
      r = (death && !pd) ? 3 : (eatghost && !pg) ? 2 : (chomp && !pc) ? 1 : 0;
      if (r != 0 && r >= cur) begin
        cur = r; t = 0;
      end else if (cur != 0) begin
        if (t == dur_of(cur) - 1) begin cur = 0; t = 0; end
        else t++;
      end
      pc = chomp; pg = eatghost; pd = death; mq = mute;
    end
  end
  always @(negedge clk) begin
    if (on) begin
      vectors++;
      if ($signed(writedata) != exp_wd() || busy != (cur != 0) || int'(sound_id) != cur || write != write_ready) begin
        miscompares++;
        $display("FAIL model t=%0t wd=%0d/%0d busy=%0b/%0b id=%0d/%0d write=%0b/%0b", $time,
                 $signed(writedata), exp_wd(), busy, cur != 0, sound_id, cur, write, write_ready);
      end
    end
  end
  task automatic chk(string n, int a, int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1 write_ready = 1'($urandom_range(0, 1));
  endtask
  initial begin
    tick(2);
    on = 1;
    chk("rst_wd", $signed(writedata), 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", sound_id, 0);
    reset = 0;
    tick(1);
    chomp = 1; tick(1);
    chk("ch_c0", $signed(writedata), 100); chk("ch_id", sound_id, 1);
    chomp = 0; tick(3); chk("ch_c3", $signed(writedata), -100);
    tick(3); chk("ch_c6", $signed(writedata), 100);
    tick(13); chk("ch_c19", $signed(writedata), 100); chk("ch_busy19", busy, 1);
    tick(1); chk("ch_c20_busy", busy, 0); chk("ch_c20_wd", $signed(writedata), 0);
    chomp = 1; tick(20); chk("hold_busy19", busy, 1);
    tick(1); chk("hold_busy20", busy, 0);
    tick(80); chk("hold_busy100", busy, 0);
    chomp = 0; tick(1);
    chomp = 1; tick(1); chomp = 0; tick(4);
    eatghost = 1; tick(1);
    chk("pre_id", sound_id, 2); chk("pre_wd", $signed(writedata), 100);
    eatghost = 0; tick(2); chk("g_c2", $signed(writedata), -100);
    tick(6); chk("g_c8", $signed(writedata), 100);
    tick(2); chk("g_c10", $signed(writedata), 100);
    tick(2); chk("g_c12", $signed(writedata), -100);
    tick(17); chk("g_c29_id", sound_id, 2);
    tick(1); chk("g_c30_busy", busy, 0);
    death = 1; tick(1); death = 0;
    tick(6); chk("d_c6", $signed(writedata), -100);
    chomp = 1; eatghost = 1; tick(1); chk("d_ign_id", sound_id, 3);
    chomp = 0; eatghost = 0; tick(2); chk("d_c9", $signed(writedata), 100);
    tick(3); chk("d_c12", $signed(writedata), -100);
    tick(3); chk("d_c15", $signed(writedata), -100);
    tick(1); chk("d_c16", $signed(writedata), 100);
    tick(23); chk("d_c39_id", sound_id, 3);
    tick(1); chk("d_c40_busy", busy, 0);
    chomp = 1; eatghost = 1; death = 1; tick(1); chk("sim_id", sound_id, 3);
    chomp = 0; eatghost = 0; death = 0; tick(9);
    death = 1; tick(1); chk("rt_wd", $signed(writedata), 100);
    death = 0; tick(39); chk("rt_busy49", busy, 1);
    tick(1); chk("rt_busy50", busy, 0);
    mute = 1; chomp = 1; tick(1); chk("mute_wd", $signed(writedata), 0); chk("mute_busy", busy, 1);
    chomp = 0; tick(19); chk("mute_busy19", busy, 1);
    tick(1); chk("mute_busy20", busy, 0);
    mute = 0;
    write_ready = 1; #1 chk("write1", write, 1);
    write_ready = 0; #1 chk("write0", write, 0);
    eatghost = 1; tick(1); eatghost = 0; tick(7);
    reset = 1; death = 1; tick(1);
    chk("rst_mid_id", sound_id, 0); chk("rst_mid_wd", $signed(writedata), 0);
    reset = 0; tick(1); chk("post_rst_id", sound_id, 3);
    death = 0;
    for (int i = 0; i < 3000; i++) begin
      chomp = ($urandom_range(0, 11) == 0);
      eatghost = ($urandom_range(0, 29) == 0);
      death = ($urandom_range(0, 79) == 0);
      mute = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset = 0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
